// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - core-side load/store request and response bundle
interface mem_access_unit_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store front end with sub-word read-modify-write
module mem_access_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_data_in,
  output logic              dmem_read_write,
  output logic              dmem_enable,
  input  logic [DATA_W-1:0] dmem_data_out
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t      state;
  logic        wr_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        req_bad;

  always_comb begin
    req_bad = 1'b0;
    case (bus.req_size)
      2'd1:    req_bad = bus.req_addr[0];
      2'd2:    req_bad = |bus.req_addr[1:0];
      2'd3:    req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
  end

  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] w,
                                                input logic [1:0] sz,
                                                input logic [1:0] lane,
                                                input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Only the addressed lane changes; the rest of the captured word is written back as read.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] w,
                                              input logic [1:0] sz,
                                              input logic [1:0] lane,
                                              input logic [15:0] d);
    logic [DATA_W-1:0] m;
    m = w;
    if (sz == 2'd0)
      m[{lane, 3'b000} +: 8] = d[7:0];
    else if (lane[1])
      m[31:16] = d;
    else
      m[15:0] = d;
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_err    <= 1'b0;
      bus.resp_rdata  <= '0;
      dmem_enable     <= 1'b0;
      dmem_read_write <= 1'b0;
      dmem_address    <= '0;
      dmem_data_in    <= '0;
      wr_q            <= 1'b0;
      uns_q           <= 1'b0;
      size_q          <= 2'd0;
      lane_q          <= 2'd0;
      wdata_q         <= '0;
    end else begin
      bus.resp_valid  <= 1'b0;
      dmem_enable     <= 1'b0;
      dmem_read_write <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            wr_q           <= bus.req_write;
            uns_q          <= bus.req_unsigned;
            size_q         <= bus.req_size;
            lane_q         <= bus.req_addr[1:0];
            wdata_q        <= bus.req_wdata[15:0];
            bus.req_ready  <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            if (req_bad) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
            end else begin
              dmem_enable  <= 1'b1;
              dmem_address <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              if (bus.req_write && bus.req_size == 2'd2) begin
                state           <= WR;
                dmem_read_write <= 1'b1;
                dmem_data_in    <= bus.req_wdata;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          if (wr_q) begin
            state           <= WR;
            dmem_enable     <= 1'b1;
            dmem_read_write <= 1'b1;
            dmem_data_in    <= merge(dmem_data_out, size_q, lane_q, wdata_q);
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= extract(dmem_data_out, size_q, lane_q, uns_q);
          end
        end
        WR: begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
        end
        RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
